// File: rtl/expr_tx.sv
// expr_tx: serializes BCD operands and +/* operators as an ASCII expression over valid/ready
module expr_tx #(
  parameter int MAX_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [3:0]             n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [(MAX_TERMS>1 ? MAX_TERMS-1 : 1)-1:0] ops,
  input  logic                   ready,
  output logic [7:0]             out,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int OW = MAX_TERMS > 1 ? MAX_TERMS - 1 : 1;
  typedef enum logic [1:0] {IDLE, SEND_D, SEND_O} state_t;
  state_t st;
  logic [3:0] idx, nt;
  logic [4*MAX_TERMS-1:0] dl, dn;
  logic [OW-1:0] ol;
  logic bad;
  // latched operands shift down so the current term always sits in the low bits
  assign dn = dl >> 4;
  always_comb begin
    bad = n_terms == 4'd0 || 32'(n_terms) > MAX_TERMS;
    for (int k = 0; k < MAX_TERMS; k++)
      if (k < 32'(n_terms) && digits[4*k +: 4] > 4'd9) bad = 1'b1;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st    <= IDLE;
      out   <= 8'h00;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      idx   <= 4'd0;
      nt    <= 4'd0;
      dl    <= '0;
      ol    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (st)
        IDLE: if (start) begin
          if (bad) err <= 1'b1;
          else begin
            dl    <= digits;
            ol    <= ops;
            nt    <= n_terms;
            idx   <= 4'd0;
            out   <= {4'h3, digits[3:0]};
            valid <= 1'b1;
            busy  <= 1'b1;
            st    <= SEND_D;
          end
        end
        SEND_D: if (ready) begin
          if (idx == nt - 4'd1) begin
            out   <= 8'h00;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            st    <= IDLE;
          end else begin
            out <= ol[0] ? 8'h2A : 8'h2B;
            ol  <= ol >> 1;
            st  <= SEND_O;
          end
        end
        SEND_O: if (ready) begin
          idx <= idx + 4'd1;
          dl  <= dn;
          out <= {4'h3, dn[3:0]};
          st  <= SEND_D;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_expr_tx.sv
// tb_expr_tx: directed self-checking bench for expr_tx
module tb_expr_tx;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n_terms = 4'd0;
  logic [31:0] digits = 32'd0;
  logic [6:0]  ops = 7'd0;
  logic        ready = 1'b1;
  logic [7:0]  out;
  logic        valid, busy, done, err;
  int checks = 0;
  int failures = 0;
  logic [7:0] seq3 [5] = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};

  expr_tx #(.MAX_TERMS(8)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .n_terms(n_terms), .digits(digits),
    .ops(ops), .ready(ready), .out(out), .valid(valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out, valid, busy, done, err} !== 12'h000) begin
      failures++;
      $display("FAIL reset: out=%h valid=%b busy=%b done=%b err=%b, want all 0", out, valid, busy, done, err);
    end
    @(negedge clk);
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    n_terms = 4'd1; digits = 32'h7; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || out !== 8'h37 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_byte: valid=%b out=%h busy=%b, want 1 37 1", valid, out, busy);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: valid=%b done=%b busy=%b, want 0 1 0", valid, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_three_terms;
    n_terms = 4'd3; digits = 32'h321; ops = 7'b0000010; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid !== 1'b1 || out !== seq3[i]) begin
        failures++;
        $display("FAIL three_terms byte%0d: valid=%b out=%h, want 1 %h", i, valid, out, seq3[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL three_terms_done: done=%b valid=%b err=%b, want 1 0 0", done, valid, err);
    end
    tick();
  endtask

  task automatic test_stall;
    n_terms = 4'd3; digits = 32'h321; ops = 7'b0000010; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          checks++;
          if (valid !== 1'b1 || out !== 8'h2B) begin
            failures++;
            $display("FAIL stall cycle%0d: valid=%b out=%h, want 1 2b", s, valid, out);
          end
          tick();
        end
        ready = 1'b1;
      end
      checks++;
      if (valid !== 1'b1 || out !== seq3[i]) begin
        failures++;
        $display("FAIL stall byte%0d: valid=%b out=%h, want 1 %h", i, valid, out, seq3[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_done: done=%b valid=%b, want 1 0", done, valid);
    end
    tick();
  endtask

  task automatic test_reject;
    logic [3:0] bad_n [3] = '{4'd2, 4'd0, 4'd9};
    for (int t = 0; t < 3; t++) begin
      n_terms = bad_n[t]; digits = 32'hA1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reject n=%0d: err=%b valid=%b busy=%b done=%b, want 1 0 0 0", bad_n[t], err, valid, busy, done);
      end
      tick();
      checks++;
      if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reject_after n=%0d: err=%b valid=%b busy=%b, want 0 0 0", bad_n[t], err, valid, busy);
      end
    end
  endtask

  task automatic test_ignore_busy;
    n_terms = 4'd3; digits = 32'h321; ops = 7'b0000010; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; digits = 32'h999; ops = 7'b1111111; n_terms = 4'd1;
      end
      checks++;
      if (valid !== 1'b1 || out !== seq3[i] || err !== 1'b0) begin
        failures++;
        $display("FAIL ignore_busy byte%0d: valid=%b out=%h err=%b, want 1 %h 0", i, valid, out, err, seq3[i]);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy_done: done=%b valid=%b, want 1 0", done, valid);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    n_terms = 4'd1; digits = 32'h5; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || out !== 8'h35) begin
      failures++;
      $display("FAIL b2b_first: valid=%b out=%h, want 1 35", valid, out);
    end
    tick();
    digits = 32'h6; start = 1'b1;
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: done=%b valid=%b, want 1 0", done, valid);
    end
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || out !== 8'h36 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: valid=%b out=%h done=%b, want 1 36 0", valid, out, done);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_midreset;
    n_terms = 4'd3; digits = 32'h321; ops = 7'b0000010; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || out !== 8'h2B) begin
      failures++;
      $display("FAIL midreset_pre: valid=%b out=%h, want 1 2b", valid, out);
    end
    #1 clr_n = 1'b0;
    #1;
    checks++;
    if ({out, valid, busy, done, err} !== 12'h000) begin
      failures++;
      $display("FAIL midreset_async: out=%h valid=%b busy=%b done=%b err=%b, want all 0", out, valid, busy, done, err);
    end
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_resume: valid=%b busy=%b, want 0 0", valid, busy);
    end
    n_terms = 4'd1; digits = 32'h9; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || out !== 8'h39) begin
      failures++;
      $display("FAIL midreset_restart: valid=%b out=%h, want 1 39", valid, out);
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_done: done=%b valid=%b, want 1 0", done, valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_terms();
    test_stall();
    test_reject();
    test_ignore_busy();
    test_back_to_back();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
